// File: rtl/clk_gen_multi.sv
// Multi-mode clock divider: picks one of NUM_MODES half-period entries and switches on a falling toggle.
// Optional single-step gating when CLK_GEN_STEP_EN is defined.

module syncEdge (
    input  logic i_clock50,
    input  logic i_nReset,
    input  logic i_async,
    output logic o_rise
);
    logic [2:0] syncPipe;

    always_ff @(posedge i_clock50 or negedge i_nReset) begin
        if (!i_nReset) syncPipe <= '0;
        else           syncPipe <= {syncPipe[1:0], i_async};
    end

    assign o_rise = syncPipe[1] & ~syncPipe[2];
endmodule

module clk_gen_multi #(
    parameter int NUM_MODES = 2,
    parameter int CNT_W     = 24,
    parameter logic [NUM_MODES*CNT_W-1:0] DIV_TABLE = {24'h5F5E10, 24'h3},
    parameter int INIT_MODE = 0,
    parameter int MODE_W    = $clog2(NUM_MODES)
) (
    input  logic              i_clock50,
    input  logic              i_nReset,
    input  logic              i_switchFreq,
    input  logic              i_modeLoad,
    input  logic [MODE_W-1:0] i_modeVal,
`ifdef CLK_GEN_STEP_EN
    input  logic              i_stepEn,
    input  logic              i_stepPulse,
`endif
    output logic              o_genClk,
    output logic              o_tick,
    output logic [MODE_W-1:0] o_mode,
    output logic              o_busy
);
    localparam logic [MODE_W:0]   NUM_M     = (MODE_W+1)'(NUM_MODES);
    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES-1);

    logic [CNT_W-1:0]  cnt, thrRaw, thr;
    logic [MODE_W-1:0] pendMode, pendNext;
    logic              swReq, phaseDone, toggle, hold;

    syncEdge uSwSync (
        .i_clock50 (i_clock50),
        .i_nReset  (i_nReset),
        .i_async   (i_switchFreq),
        .o_rise    (swReq)
    );

    // A load strobe owns the cycle: any coincident button request is dropped.
    always_comb begin
        pendNext = pendMode;
        if (i_modeLoad) begin
            if ({1'b0, i_modeVal} < NUM_M) pendNext = i_modeVal;
        end else if (swReq) begin
            pendNext = (pendMode == LAST_MODE) ? '0 : pendMode + MODE_W'(1);
        end
    end

    always_comb begin
        thrRaw = '0;
        for (int k = 0; k < NUM_MODES; k++)
            if (o_mode == MODE_W'(k)) thrRaw = DIV_TABLE[k*CNT_W +: CNT_W];
        thr = (thrRaw == '0) ? CNT_W'(1) : thrRaw;
    end

    assign phaseDone = ({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, thr};

`ifdef CLK_GEN_STEP_EN
    logic [1:0] stepEnPipe;
    logic       stepEnS, stepRise, stepPend, held, lowDone;

    syncEdge uStepSync (
        .i_clock50 (i_clock50),
        .i_nReset  (i_nReset),
        .i_async   (i_stepPulse),
        .o_rise    (stepRise)
    );

    assign stepEnS = stepEnPipe[1];
    // Low phase counts as finished once it ran its length or is parked in hold.
    assign lowDone = !o_genClk && (phaseDone || held);

    always_comb begin
        toggle = 1'b0;
        hold   = 1'b0;
        if (o_genClk)       toggle = phaseDone;
        else if (!stepEnS)  toggle = lowDone;
        else if (lowDone) begin
            toggle = stepPend;
            hold   = !stepPend;
        end
    end

    always_ff @(posedge i_clock50 or negedge i_nReset) begin
        if (!i_nReset) begin
            stepEnPipe <= '0;
            stepPend   <= 1'b0;
            held       <= 1'b0;
        end else begin
            stepEnPipe <= {stepEnPipe[0], i_stepEn};
            if (!stepEnS)                  stepPend <= 1'b0;
            else if (stepRise)             stepPend <= 1'b1;
            else if (toggle && !o_genClk)  stepPend <= 1'b0;
            if (toggle)    held <= 1'b0;
            else if (hold) held <= 1'b1;
        end
    end
`else
    assign toggle = phaseDone;
    assign hold   = 1'b0;
`endif

    always_ff @(posedge i_clock50 or negedge i_nReset) begin
        if (!i_nReset) begin
            cnt      <= '0;
            o_genClk <= 1'b0;
            o_tick   <= 1'b0;
            o_mode   <= MODE_W'(INIT_MODE);
            pendMode <= MODE_W'(INIT_MODE);
        end else begin
            pendMode <= pendNext;
            o_tick   <= toggle && !o_genClk;
            if (toggle) begin
                o_genClk <= ~o_genClk;
                cnt      <= '0;
                // Mode only changes entering a low phase, so no phase is ever cut short.
                if (o_genClk) o_mode <= pendMode;
            end else if (hold) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign o_busy = (pendMode != o_mode);
endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed bench for clk_gen_multi with a 3-mode table {5,3,1}.
module tb_clk_gen_multi;
    logic       clk, nReset, switchFreq, modeLoad;
    logic [1:0] modeVal;
    logic       genClk, tick, busy;
    logic [1:0] mode;
`ifdef CLK_GEN_STEP_EN
    logic       stepEn, stepPulse;
`endif

    int nChecks = 0;
    int nErr    = 0;
    int tickBad = 0;
    logic prevGen = 1'b0;

    clk_gen_multi #(
        .NUM_MODES (3),
        .CNT_W     (8),
        .DIV_TABLE ({8'd5, 8'd3, 8'd1}),
        .INIT_MODE (0)
    ) dut (
        .i_clock50    (clk),
        .i_nReset     (nReset),
        .i_switchFreq (switchFreq),
        .i_modeLoad   (modeLoad),
        .i_modeVal    (modeVal),
`ifdef CLK_GEN_STEP_EN
        .i_stepEn     (stepEn),
        .i_stepPulse  (stepPulse),
`endif
        .o_genClk     (genClk),
        .o_tick       (tick),
        .o_mode       (mode),
        .o_busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // o_tick must mark exactly the samples where genClk has just risen.
    always @(negedge clk) begin
        if (!nReset) prevGen = 1'b0;
        else begin
            if (tick !== (genClk & ~prevGen)) tickBad++;
            prevGen = genClk;
        end
    end

    // Waits for the next rising transition, then measures high and low lengths in cycles.
    task automatic measPeriod(output int hi, output int lo);
        int n;
        logic prev;
        n = 0; hi = -1; lo = -1;
        @(negedge clk);
        prev = genClk;
        @(negedge clk);
        while (!(!prev && genClk) && n < 300) begin
            prev = genClk;
            @(negedge clk);
            n++;
        end
        if (n >= 300) return;
        hi = 0;
        while (genClk && n < 300) begin hi++; @(negedge clk); n++; end
        lo = 0;
        while (!genClk && n < 300) begin lo++; @(negedge clk); n++; end
        if (n >= 300) begin hi = -1; lo = -1; end
    endtask

    task automatic waitMode(input int m);
        int n = 0;
        while (int'(mode) != m && n < 100) begin @(negedge clk); n++; end
        chk("waitMode", mode, m);
    endtask

    task automatic loadMode(input logic [1:0] v);
        @(negedge clk);
        modeLoad = 1'b1; modeVal = v;
        @(negedge clk);
        modeLoad = 1'b0;
    endtask

    initial begin
        int hi, lo, n;
        int expMode [3] = '{1, 2, 0};
        int expHalf [3] = '{3, 5, 1};
        int lsStart [2] = '{0, 1};
        int lsVal   [2] = '{1, 0};
        nReset = 1'b0; switchFreq = 1'b0; modeLoad = 1'b0; modeVal = '0;
`ifdef CLK_GEN_STEP_EN
        stepEn = 1'b0; stepPulse = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_genClk", genClk, 0);
        chk("rst_tick", tick, 0);
        chk("rst_mode", mode, 0);
        chk("rst_busy", busy, 0);
        nReset = 1'b1;

        measPeriod(hi, lo);
        chk("m0_hi", hi, 1);
        chk("m0_lo", lo, 1);
        chk("m0_mode", mode, 0);
        chk("m0_busy", busy, 0);
        n = 0;
        repeat (10) begin @(negedge clk); n += int'(tick); end
        chk("m0_ticks", n, 5);

        // Load mode 2 so it is captured as the mode-0 high phase begins.
        if (genClk) @(negedge clk);
        modeLoad = 1'b1; modeVal = 2'd2;
        @(negedge clk);
        modeLoad = 1'b0;
        chk("ld_hi", genClk, 1);
        chk("ld_busy", busy, 1);
        chk("ld_modeOld", mode, 0);
        @(negedge clk);
        chk("ld_fall", genClk, 0);
        chk("ld_mode", mode, 2);
        chk("ld_busyDrop", busy, 0);
        n = 0;
        while (!genClk && n < 50) begin n++; @(negedge clk); end
        chk("ld_firstLo", n, 5);
        measPeriod(hi, lo);
        chk("ld_hi5", hi, 5);
        chk("ld_lo5", lo, 5);

        loadMode(2'd0);
        waitMode(0);
        for (int i = 0; i < 3; i++) begin
            switchFreq = 1'b1;
            repeat (2) @(negedge clk);
            switchFreq = 1'b0;
            repeat (20) @(negedge clk);
            chk($sformatf("sw%0d_mode", i), mode, expMode[i]);
            measPeriod(hi, lo);
            chk($sformatf("sw%0d_hi", i), hi, expHalf[i]);
            chk($sformatf("sw%0d_lo", i), lo, expHalf[i]);
        end

        loadMode(2'd3);
        chk("inv_busy", busy, 0);
        repeat (10) @(negedge clk);
        chk("inv_mode", mode, 0);

        // Button request lands on the same edge as the load strobe.
        for (int i = 0; i < 2; i++) begin
            loadMode(2'(lsStart[i]));
            waitMode(lsStart[i]);
            switchFreq = 1'b1;
            @(negedge clk);
            @(negedge clk);
            modeLoad = 1'b1; modeVal = 2'(lsVal[i]);
            @(negedge clk);
            modeLoad = 1'b0; switchFreq = 1'b0;
            repeat (20) @(negedge clk);
            chk($sformatf("ls%0d_mode", i), mode, lsVal[i]);
            chk($sformatf("ls%0d_busy", i), busy, 0);
        end

        loadMode(2'd2);
        waitMode(2);
        n = 0;
        while (!genClk && n < 50) begin n++; @(negedge clk); end
        switchFreq = 1'b1;
        @(negedge clk);
        chk("rs_preHi", genClk, 1);
        #2 nReset = 1'b0;
        #1;
        chk("rs_genClk", genClk, 0);
        chk("rs_mode", mode, 0);
        chk("rs_busy", busy, 0);
        switchFreq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nReset = 1'b1;
        repeat (20) @(negedge clk);
        chk("rs_modeAfter", mode, 0);
        chk("rs_busyAfter", busy, 0);
        measPeriod(hi, lo);
        chk("rs_hi", hi, 1);
        chk("rs_lo", lo, 1);

`ifdef CLK_GEN_STEP_EN
        begin
            int hiCnt, tk;
            loadMode(2'd1);
            waitMode(1);
            stepEn = 1'b1;
            repeat (20) @(negedge clk);
            hiCnt = 0;
            repeat (10) begin @(negedge clk); hiCnt += int'(genClk); end
            chk("st_held", hiCnt, 0);
            hiCnt = 0; tk = 0;
            for (int i = 0; i < 40; i++) begin
                if (i == 0 || i == 15) stepPulse = 1'b1;
                if (i == 2 || i == 17) stepPulse = 1'b0;
                @(negedge clk);
                hiCnt += int'(genClk);
                tk += int'(tick);
            end
            chk("st_highs", hiCnt, 6);
            chk("st_ticks", tk, 2);
            chk("st_heldEnd", genClk, 0);
            stepEn = 1'b0;
            repeat (10) @(negedge clk);
            measPeriod(hi, lo);
            chk("st_freeHi", hi, 3);
            chk("st_freeLo", lo, 3);
        end
`endif

        chk("tickAlign", tickBad, 0);
        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end
endmodule
